// File: rtl/pattern_det.sv
// pattern_det: Mealy sequence detector for the serial pattern 1-0-1-1-0
// (first-received bit first). Only bits with valid_in=1 are consumed, and
// overlapping occurrences are detected.
// Optional build macro DET_COUNT_EN adds a saturating detection counter
// (det_count, width CNT_W).
module pattern_det
`ifdef DET_COUNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    input  logic             valid_in,
    output logic             pattern_detected
`ifdef DET_COUNT_EN
    ,
    output logic [CNT_W-1:0] det_count
`endif
);

    // Each state is named for the longest prefix of the pattern matched so far.
    typedef enum logic [2:0] {
        S0 = 3'd0,  // nothing matched
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "10"
        S3 = 3'd3,  // "101"
        S4 = 3'd4   // "1011"
    } state_t;

    state_t state;
    state_t next_state;

    // State register; reset discards any partial match.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Mealy output. d_in is examined only when valid_in=1,
    // so an X on d_in during an idle cycle cannot reach the state.
    always_comb begin
        next_state       = state;
        pattern_detected = 1'b0;
        if (valid_in) begin
            case (state)
                S0: next_state = d_in ? S1 : S0;
                S1: next_state = d_in ? S1 : S2;
                S2: next_state = d_in ? S3 : S0;
                S3: next_state = d_in ? S4 : S2;
                S4: begin
                    // A detect keeps the trailing "10" so overlapping matches work.
                    next_state       = d_in ? S1 : S2;
                    pattern_detected = ~d_in & ~rst;
                end
                default: next_state = S0;
            endcase
        end
    end

`ifdef DET_COUNT_EN
    // Saturating count of detections; holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            det_count <= '0;
        end else if (pattern_detected && (det_count != '1)) begin
            det_count <= det_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pattern_det.sv
// Testbench for pattern_det. Expected detect values come from a bit-history
// reference model and are queued as each step is driven, then popped and
// compared against the DUT output sampled mid-cycle.
module tb_pattern_det;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_in;
    logic        valid_in;
    logic        pattern_detected;
`ifdef DET_COUNT_EN
    logic [15:0] det_count;
`endif

    pattern_det dut (
        .clk              (clk),
        .rst              (rst),
        .d_in             (d_in),
        .valid_in         (valid_in),
        .pattern_detected (pattern_detected)
`ifdef DET_COUNT_EN
        ,
        .det_count        (det_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: the last four valid bits since reset, plus how many
    // valid bits have been seen since reset.
    logic [3:0]  hist    = '0;
    int unsigned nbits   = 0;
    int unsigned cnt_exp = 0;
    int unsigned det_exp_total = 0;

    logic        exp_q[$];
    logic        prev_det = 1'b0;
    int unsigned edges = 0;

    // One clock cycle: drive at negedge, check mid-cycle, update the model
    // at the following posedge.
    task automatic step(input logic r, input logic v, input logic d, input string tag);
        logic exp_det;
        logic obs;
        @(negedge clk);
        rst      = r;
        valid_in = v;
        d_in     = d;
        exp_det  = 1'b0;
        if (!r && v && (d === 1'b0) && (nbits >= 4) && (hist == 4'b1011)) exp_det = 1'b1;
        exp_q.push_back(exp_det);
        #2;
        obs = pattern_detected;
        total++;
        assert (obs === exp_q.pop_front())
        else begin
            bad++;
            $error("FAIL %s: pattern_detected=%b expected=%b", tag, obs, exp_det);
        end
`ifdef DET_COUNT_EN
        total++;
        assert (det_count === 16'(cnt_exp))
        else begin
            bad++;
            $error("FAIL %s_count: det_count=%0d expected=%0d", tag, det_count, cnt_exp);
        end
`endif
        if (obs === 1'b1 && prev_det !== 1'b1) edges++;
        prev_det = obs;
        @(posedge clk);
        if (r) begin
            hist    = '0;
            nbits   = 0;
            cnt_exp = 0;
        end else if (v) begin
            hist = {hist[2:0], d};
            nbits++;
            if (exp_det) begin
                det_exp_total++;
                if (cnt_exp < 16'hFFFF) cnt_exp++;
            end
        end
    endtask

    task automatic feed(input logic [15:0] bits, input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b1, bits[n-1-i], tag);
    endtask

    task automatic check_edges(input int unsigned base, input int unsigned want, input string tag);
        total++;
        assert ((edges - base) === want)
        else begin
            bad++;
            $error("FAIL %s: edges=%0d expected=%0d", tag, edges - base, want);
        end
    endtask

    initial begin
        int unsigned base;
        int unsigned soak_exp_base;

        rst = 1'b1; valid_in = 1'b1; d_in = 1'b1;

        // Reset held with valid 1s: never detects.
        step(1'b1, 1'b1, 1'b1, "reset0");
        step(1'b1, 1'b1, 1'b1, "reset1");

        // Single pattern.
        base = edges;
        feed(16'b10110, 5, "single");
        check_edges(base, 1, "single_edges");

        // Flush back to a known state with zeros.
        feed(16'b000, 3, "flush");

        // Overlapping patterns.
        base = edges;
        feed(16'b10110110, 8, "overlap");
        check_edges(base, 2, "overlap_edges");
        feed(16'b000, 3, "flush");

        // Near miss.
        base = edges;
        feed(16'b101110, 6, "nearmiss");
        check_edges(base, 0, "nearmiss_edges");
        feed(16'b000, 3, "flush");

        // Bubbles with d_in = 0 and X; detect on the final valid 0.
        base = edges;
        feed(16'b1011, 4, "bubble_pre");
        step(1'b0, 1'b0, 1'b0, "bubble0");
        step(1'b0, 1'b0, 1'bx, "bubbleX");
        step(1'b0, 1'b0, 1'b0, "bubble0b");
        step(1'b0, 1'b1, 1'b0, "bubble_end");
        check_edges(base, 1, "bubble_edges");
        feed(16'b000, 3, "flush");

        // Reset mid-pattern discards the partial match.
        base = edges;
        feed(16'b1011, 4, "midrst_pre");
        step(1'b1, 1'b0, 1'b0, "midrst");
        step(1'b0, 1'b1, 1'b0, "midrst_post");
        check_edges(base, 0, "midrst_edges");
        feed(16'b10110, 5, "after_rst");
        check_edges(base, 1, "after_rst_edges");

        // Random soak: 540 valid bits with occasional idle cycles carrying X.
        base = edges;
        soak_exp_base = det_exp_total;
        for (int unsigned i = 0; i < 540; i++) begin
            if ($urandom_range(0, 7) == 0) step(1'b0, 1'b0, 1'bx, "soak_idle");
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), "soak");
        end
        check_edges(base, det_exp_total - soak_exp_base, "soak_edges");

        total++;
        assert (exp_q.size() === 0)
        else begin
            bad++;
            $error("FAIL queue_drain: size=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
